full_add_4bit: RTL and testbench

Registered 4-bit binary adder with carry-in, producing a 4-bit sum, an unsigned carry-out flag (`overflow`) and a signed two's-complement overflow flag (`v`). It is a small arithmetic leaf block used wherever a clocked nibble add is needed. It is built as a ripple of four 1-bit full adders, followed by an output register stage on a single clock with asynchronous active-low reset.

---
 rtl/full_add_4bit_pkg.sv | 12 +
 rtl/full_add_4bit_full_adder.sv | 13 +
 rtl/full_add_4bit.sv | 47 ++++
 tb/tb_full_add_4bit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/full_add_4bit_pkg.sv
// Shared constants and result payload for the registered nibble adder.
package full_add_4bit_pkg;

   localparam int unsigned WIDTH = 4;

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             overflow;
      logic             v;
   } add_res_t;

endpackage

// File: rtl/full_add_4bit_full_adder.sv
// 1-bit full adder: the ripple-chain building block.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_add_4bit.sv
// Registered 4-bit ripple-carry adder with unsigned carry-out and signed overflow flags.
module full_add_4bit
   import full_add_4bit_pkg::*;
(
   output logic [WIDTH-1:0] s,
   output logic             overflow,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Cin,
   input  logic             clk,
   input  logic             rst_n,
   output logic             v
);

   // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out
   logic             carry [WIDTH+1];
   logic [WIDTH-1:0] sum_c;
   add_res_t         res_q;

   assign carry[0] = Cin;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (sum_c[i]),
         .cout (carry[i+1])
      );
   end

   // Output register stage; signed overflow is carry-in xor carry-out of the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else begin
         res_q <= '{s:        sum_c,
                    overflow: carry[WIDTH],
                    v:        carry[WIDTH] ^ carry[WIDTH-1]};
      end
   end

   assign s        = res_q.s;
   assign overflow = res_q.overflow;
   assign v        = res_q.v;

endmodule

// File: tb/tb_full_add_4bit.sv
// Self-checking bench for full_add_4bit: directed table, reset corners, exhaustive and random sweeps.
module tb_full_add_4bit;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] s;
      logic       ov;
      logic       v;
   } vec_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] a     = 4'h0;
   logic [3:0] b     = 4'h0;
   logic       Cin   = 1'b0;
   logic [3:0] s;
   logic       overflow;
   logic       v;

   int total = 0;
   int bad   = 0;

   full_add_4bit dut (
      .s        (s),
      .overflow (overflow),
      .a        (a),
      .b        (b),
      .Cin      (Cin),
      .clk      (clk),
      .rst_n    (rst_n),
      .v        (v)
   );

   always #5 clk = ~clk;

   // Arithmetic reference: unsigned sum, with signed overflow from the sign rule
   function automatic logic [5:0] ref_model(input logic [3:0] x, input logic [3:0] y,
                                            input logic ci);
      logic [4:0] sum5;
      logic       vf;
      sum5 = 5'(x) + 5'(y) + 5'(ci);
      vf   = (x[3] == y[3]) && (sum5[3] != x[3]);
      return {sum5[3:0], sum5[4], vf};
   endfunction

   task automatic check(input string name, input logic [5:0] exp);
      total++;
      if ({s, overflow, v} !== exp) begin
         bad++;
         $display("FAIL %s: got s=%b ov=%b v=%b, want s=%b ov=%b v=%b",
                  name, s, overflow, v, exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic ci);
      @(negedge clk);
      a   = x;
      b   = y;
      Cin = ci;
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{a: 4'b1001, b: 4'b1100, cin: 1'b0, s: 4'b0101, ov: 1'b1, v: 1'b1};
      tbl[1] = '{a: 4'b1100, b: 4'b1001, cin: 1'b1, s: 4'b0110, ov: 1'b1, v: 1'b1};
      tbl[2] = '{a: 4'b1000, b: 4'b1000, cin: 1'b1, s: 4'b0001, ov: 1'b1, v: 1'b1};
      tbl[3] = '{a: 4'b0011, b: 4'b0100, cin: 1'b0, s: 4'b0111, ov: 1'b0, v: 1'b0};
      tbl[4] = '{a: 4'b1111, b: 4'b0000, cin: 1'b1, s: 4'b0000, ov: 1'b1, v: 1'b0};
      tbl[5] = '{a: 4'b0111, b: 4'b0000, cin: 1'b1, s: 4'b1000, ov: 1'b0, v: 1'b1};

      // Reset held with all-ones inputs and a running clock
      a = 4'hF; b = 4'hF; Cin = 1'b1;
      #2;
      check("reset_t0", 6'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", 6'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table, back to back
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].a, tbl[i].b, tbl[i].cin);
         check($sformatf("table_%0d", i), {tbl[i].s, tbl[i].ov, tbl[i].v});
      end

      // Input changes between edges must not reach the outputs
      drive(4'b1001, 4'b1100, 1'b0);
      a = 4'b0001; b = 4'b0001; Cin = 1'b0;
      #2;
      check("hold_between_edges", 6'b0101_1_1);

      // Asynchronous reset between edges on a nonzero result
      drive(4'b1000, 4'b1000, 1'b1);
      check("pre_async_reset", 6'b0001_1_1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", 6'b0);
      @(posedge clk);
      #1;
      check("async_reset_edge", 6'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0111, 4'b0000, 1'b1);
      check("first_after_reset", 6'b1000_0_1);

      // Exhaustive sweep with a mid-stream reset
      for (int i = 0; i < 512; i++) begin
         logic [3:0] x;
         logic [3:0] y;
         logic       ci;
         x  = 4'(i >> 5);
         y  = 4'(i >> 1);
         ci = 1'(i);
         drive(x, y, ci);
         check($sformatf("exh_%0d", i), ref_model(x, y, ci));
         if (i == 300) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("exh_mid_reset", 6'b0);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      // Random stimulus
      for (int i = 0; i < 200; i++) begin
         logic [3:0] x;
         logic [3:0] y;
         logic       ci;
         x  = 4'($urandom_range(15, 0));
         y  = 4'($urandom_range(15, 0));
         ci = 1'($urandom_range(1, 0));
         drive(x, y, ci);
         check($sformatf("rand_%0d", i), ref_model(x, y, ci));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
